// File: rtl/io_result_streamer_pkg.sv
// Shared types and helpers for the IO result streamer.
// Build option: `define IO_DROP_COUNT_EN enables the saturating drop counter.
package io_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_t;

  // Number of BYTEW-wide symbols needed to carry a WIDTH-bit word.
  function automatic int nbytes(input int width, input int bytew);
    return (width + bytew - 1) / bytew;
  endfunction

endpackage

// File: rtl/io_result_streamer_fifo.sv
// Register-array synchronous FIFO used to buffer captured results.
// A push at full is accepted when a pop happens on the same edge.
module fifo_sync #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wPtr_r;
  logic [AW-1:0]    rPtr_r;
  logic [AW:0]      count_r;
  logic             doPush_s;
  logic             doPop_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    doPop_s  = pop && !empty;
    doPush_s = push && (!full || doPop_s);
  end

  // Storage array and pointers; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wPtr_r <= '0;
      rPtr_r <= '0;
    end else begin
      if (doPush_s) begin
        mem_r[wPtr_r] <= wdata;
        wPtr_r        <= wPtr_r + AW'(1);
      end
      if (doPop_s) begin
        rPtr_r <= rPtr_r + AW'(1);
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign rdata = mem_r[rPtr_r];

endmodule

// File: rtl/io_result_streamer.sv
// Captures flagged core results into a FIFO and streams each word out
// LSB byte first over a valid/ready handshake.
// Build option: `define IO_DROP_COUNT_EN adds a saturating dropped-capture counter.
module io_result_streamer
  import io_stream_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  parameter int BYTEW = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     captureValid,
  input  logic [WIDTH-1:0]         captureData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [BYTEW-1:0]         outByte,
  output logic                     outLast,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     overflow,
  output logic [7:0]               dropCount
);

  localparam int NBYTES = nbytes(WIDTH, BYTEW);
  localparam int SHW    = NBYTES * BYTEW;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  stream_state_t    state_r;
  stream_state_t    stateNext_s;
  logic [SHW-1:0]   shift_r;
  logic [IW-1:0]    byteIdx_r;
  logic             last_r;
  logic             overflow_r;
  logic             fifoPush_s;
  logic             fifoPop_s;
  logic             fifoFull_s;
  logic             fifoEmpty_s;
  logic [WIDTH-1:0] fifoRdata_s;
  logic             load_s;
  logic             advance_s;
  logic             retire_s;
  logic             drop_s;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush_s),
    .pop   (fifoPop_s),
    .wdata (captureData),
    .full  (fifoFull_s),
    .empty (fifoEmpty_s),
    .count (fifoCount),
    .rdata (fifoRdata_s)
  );

  // Next-state and control decode for the IDLE/SEND streamer.
  always_comb begin
    stateNext_s = state_r;
    fifoPop_s   = 1'b0;
    load_s      = 1'b0;
    advance_s   = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifoEmpty_s) begin
          fifoPop_s   = 1'b1;
          load_s      = 1'b1;
          stateNext_s = SEND;
        end else begin
          stateNext_s = IDLE;
        end
      end
      SEND: begin
        if (outReady) begin
          if (last_r) begin
            retire_s    = 1'b1;
            stateNext_s = IDLE;
          end else begin
            advance_s   = 1'b1;
            stateNext_s = SEND;
          end
        end else begin
          stateNext_s = SEND;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Capture acceptance: room in the FIFO, or a slot freed by a same-edge pop.
  always_comb begin
    fifoPush_s = 1'b0;
    drop_s     = 1'b0;
    if (captureValid) begin
      fifoPush_s = !fifoFull_s || fifoPop_s;
      drop_s     = fifoFull_s && !fifoPop_s;
    end else begin
      fifoPush_s = 1'b0;
      drop_s     = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Shift register, byte index and last-symbol flag; cleared once a word retires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_r   <= '0;
      byteIdx_r <= '0;
      last_r    <= 1'b0;
    end else if (load_s) begin
      shift_r   <= SHW'(fifoRdata_s);
      byteIdx_r <= '0;
      last_r    <= (NBYTES == 1);
    end else if (advance_s) begin
      shift_r   <= shift_r >> BYTEW;
      byteIdx_r <= byteIdx_r + IW'(1);
      last_r    <= (byteIdx_r == IW'(NBYTES - 2));
    end else if (retire_s) begin
      shift_r   <= '0;
      byteIdx_r <= '0;
      last_r    <= 1'b0;
    end else begin
      shift_r   <= shift_r;
      byteIdx_r <= byteIdx_r;
      last_r    <= last_r;
    end
  end

  // Sticky overflow flag, set by any dropped capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef IO_DROP_COUNT_EN
  logic [7:0] dropCount_r;

  // Saturating count of dropped captures.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropCount_r <= 8'h00;
    end else if (drop_s && (dropCount_r != 8'hFF)) begin
      dropCount_r <= dropCount_r + 8'h01;
    end else begin
      dropCount_r <= dropCount_r;
    end
  end

  assign dropCount = dropCount_r;
`else
  assign dropCount = 8'h00;
`endif

  assign outValid = (state_r == SEND);
  assign outByte  = shift_r[BYTEW-1:0];
  assign outLast  = last_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_io_result_streamer.sv
// Scoreboard bench for io_result_streamer: a word-level model predicts
// FIFO occupancy, drops and the expected byte stream; a negedge monitor
// compares DUT outputs against it.
module tb_io_result_streamer;

  localparam int WIDTH = 36;
  localparam int DEPTH = 8;
  localparam int BYTEW = 8;
  localparam int NB    = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             captureValid = 1'b0;
  logic [WIDTH-1:0] captureData = '0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [BYTEW-1:0] outByte;
  logic             outLast;
  logic [3:0]       fifoCount;
  logic             overflow;
  logic [7:0]       dropCount;

  int passCnt  = 0;
  int checkCnt = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [7:0]       eByte[$];
  logic             eLast[$];
  bit               mSending = 1'b0;
  int               mSent = 0;
  bit               mOver = 1'b0;
  int               mDrops = 0;

  io_result_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYTEW(BYTEW)) dut (
    .clock        (clock),
    .reset        (reset),
    .captureValid (captureValid),
    .captureData  (captureData),
    .outValid     (outValid),
    .outReady     (outReady),
    .outByte      (outByte),
    .outLast      (outLast),
    .fifoCount    (fifoCount),
    .overflow     (overflow),
    .dropCount    (dropCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passCnt++;
  endtask

  // Word-level behaviour at one rising edge: sender progress, pop from IDLE, then push/drop.
  task automatic modelStep(input bit capV, input logic [WIDTH-1:0] data, input bit rdy);
    logic [39:0] w;
    if (mSending) begin
      if (rdy) begin
        mSent++;
        if (mSent == NB) mSending = 1'b0;
      end
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
      mSending = 1'b1;
      mSent    = 0;
    end
    if (capV) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(data);
        w = {4'h0, data};
        for (int b = 0; b < NB; b++) begin
          eByte.push_back(w[8*b +: 8]);
          eLast.push_back(b == NB - 1);
        end
      end else begin
        mOver = 1'b1;
`ifdef IO_DROP_COUNT_EN
        if (mDrops < 255) mDrops++;
`endif
      end
    end
  endtask

  task automatic modelClear();
    mq.delete();
    eByte.delete();
    eLast.delete();
    mSending = 1'b0;
    mSent    = 0;
    mOver    = 1'b0;
    mDrops   = 0;
  endtask

  task automatic cycle(input bit capV, input logic [WIDTH-1:0] data, input bit rdy);
    captureValid = capV;
    captureData  = data;
    outReady     = rdy;
    @(posedge clock);
    modelStep(capV, data, rdy);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic doReset(input string tag);
    captureValid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk({tag, " rst outValid"},  64'(outValid),  64'd0);
    chk({tag, " rst outByte"},   64'(outByte),   64'd0);
    chk({tag, " rst outLast"},   64'(outLast),   64'd0);
    chk({tag, " rst fifoCount"}, 64'(fifoCount), 64'd0);
    chk({tag, " rst overflow"},  64'(overflow),  64'd0);
    chk({tag, " rst dropCount"}, 64'(dropCount), 64'd0);
    modelClear();
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((mSending || mq.size() != 0) && n < 400) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    @(negedge clock);
    #1;
    chk({tag, " all bytes delivered"}, 64'(eByte.size()), 64'd0);
  endtask

  // Monitor: compare outputs with the model; consume expected bytes on handshake.
  always @(negedge clock) begin
    if (!reset) begin
      chk("outValid",  64'(outValid),  64'(mSending));
      chk("fifoCount", 64'(fifoCount), 64'(mq.size()));
      chk("overflow",  64'(overflow),  64'(mOver));
      chk("dropCount", 64'(dropCount), 64'(mDrops));
      if (outValid) begin
        if (eByte.size() == 0) begin
          chk("unexpected byte", 64'(outByte) | 64'h100, 64'd0);
        end else begin
          chk("outByte", 64'(outByte), 64'(eByte[0]));
          chk("outLast", 64'(outLast), 64'(eLast[0]));
          if (outReady) begin
            void'(eByte.pop_front());
            void'(eLast.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    // Power-on reset
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("por outValid",  64'(outValid),  64'd0);
    chk("por fifoCount", 64'(fifoCount), 64'd0);
    chk("por overflow",  64'(overflow),  64'd0);
    chk("por dropCount", 64'(dropCount), 64'd0);
    reset = 1'b0;
    cycle(1'b0, '0, 1'b1);

    // T1 single word
    cycle(1'b1, 36'h9_8765_4321, 1'b1);
    drain("T1");

    // T2 backpressure mid-word
    cycle(1'b1, 36'hA_BCDE_F012, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b0);
    drain("T2");

    // T3 fill and overflow, then T4 push at full on a pop edge
    doReset("T3");
    for (int i = 1; i <= 10; i++) cycle(1'b1, 36'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 11; i <= 30; i++) cycle(1'b1, 36'(i), 1'b1);
    drain("T4");

    // T5 reset after byte 2 of a word, then a fresh word
    cycle(1'b1, 36'h1_1223_3445, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    doReset("T5");
    cycle(1'b1, 36'h5_5667_7889, 1'b1);
    drain("T5");

    // T6 many drops (saturates with the counter enabled)
    doReset("T6");
    for (int i = 0; i < 310; i++) cycle(1'b1, 36'(i + 100), 1'b0);
    drain("T6");

    // Randomized traffic
    doReset("RND");
    for (int i = 0; i < 1500; i++) begin
      d = 36'({$urandom(), $urandom()});
      cycle($urandom_range(0, 99) < 40, d, $urandom_range(0, 99) < 60);
    end
    drain("RND");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
